// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: field layout, opcode range,
// and session state encoding.
package instr_encoder_pkg;

  localparam int INSTR_W     = 17;
  localparam int OP_W        = 5;
  localparam int FLD_W       = 3;
  localparam int OP_LSB      = 12;
  localparam int DA_LSB      = 9;
  localparam int AA_LSB      = 6;
  localparam int BA_LSB      = 3;
  localparam int IMM_LSB     = 0;
  localparam logic [OP_W-1:0] OP_ADD = 5'd0;
  localparam int NUM_OPCODES = 21;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } enc_state_e;

  // Packed order matches the memory word: opcode in the MSBs, imm in the LSBs.
  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [FLD_W-1:0] da;
    logic [FLD_W-1:0] aa;
    logic [FLD_W-1:0] ba;
    logic [FLD_W-1:0] imm;
  } instr_t;

  function automatic logic opcode_legal(input logic [OP_W-1:0] op);
    return int'(op) < NUM_OPCODES;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO holding encoded words between acceptance and the
// memory write; pointers carry an extra wrap bit to separate full from empty.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         last
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[PW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign last  = ((wr_ptr - rd_ptr) == (PW+1)'(1));

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction fields into 17-bit words and streams them to instruction
// memory from base_addr onward, one load session per start pulse.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [AW-1:0]      base_addr,
  input  logic               finish,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FLD_W-1:0]   da,
  input  logic [FLD_W-1:0]   aa,
  input  logic [FLD_W-1:0]   ba,
  input  logic [FLD_W-1:0]   imm,
  output logic               mem_we,
  input  logic               mem_ready,
  output logic [AW-1:0]      mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic               wrapped,
  output logic [AW:0]        words_written
);

  enc_state_e         state, state_nxt;
  logic               accept, legal, push, pop;
  logic               full, empty, last;
  logic [INSTR_W-1:0] head;
  instr_t             word;

  assign word   = '{opcode: opcode, da: da, aa: aa, ba: ba, imm: imm};
  assign legal  = opcode_legal(opcode);
  assign accept = in_valid && in_ready;
  assign push   = accept && legal;
  assign pop    = mem_we && mem_ready;

  sync_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (word),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // DRAIN finishes as soon as the final word leaves, so done follows the last write directly.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  if (finish) state_nxt = ST_DRAIN;
      ST_DRAIN: if (empty || (pop && last)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_LOAD: begin
        in_ready = !full;
        mem_we   = !empty;
        busy     = 1'b1;
      end
      ST_DRAIN: begin
        mem_we = !empty;
        busy   = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Stale buffer contents never leak onto the bus, including during reset.
  assign mem_wdata = mem_we ? head : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr      <= '0;
      words_written <= '0;
      illegal       <= 1'b0;
      wrapped       <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      mem_addr      <= base_addr;
      words_written <= '0;
      illegal       <= 1'b0;
      wrapped       <= 1'b0;
    end else begin
      if (pop) begin
        mem_addr      <= mem_addr + 1'b1;
        words_written <= words_written + 1'b1;
        if (&mem_addr) wrapped <= 1'b1;
      end
      if (accept && !legal) illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: encoding table, directed session sequences and
// randomized sessions checked every cycle against a queue-based model.
module tb_instr_encoder;

  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int AMAX  = (1 << AW) - 1;

  logic          clk, rst_n, start, finish, in_valid, in_ready, mem_we, mem_ready;
  logic [AW-1:0] base_addr, mem_addr;
  logic [4:0]    opcode;
  logic [2:0]    da, aa, ba, imm;
  logic [16:0]   mem_wdata;
  logic          busy, done, illegal, wrapped;
  logic [AW:0]   words_written;

  instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .finish(finish), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .da(da), .aa(aa), .ba(ba), .imm(imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .illegal(illegal),
    .wrapped(wrapped), .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // Model: session phase 0 idle, 1 loading, 2 draining, 3 done pulse.
  int          m_phase;
  int          m_addr, m_ww;
  bit          m_ill, m_wr;
  logic [16:0] m_q[$];

  typedef struct {
    int          op, da, aa, ba, imm;
    logic [16:0] exp;
  } vec_t;
  vec_t tbl[5];

  function automatic logic [16:0] enc(input int op, input int d, input int a, input int b, input int i);
    return 17'(op * 4096 + d * 512 + a * 64 + b * 8 + i);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_addr = 0; m_ww = 0; m_ill = 0; m_wr = 0;
    m_q.delete();
  endtask

  task automatic m_pop();
    void'(m_q.pop_front());
    if (m_addr == AMAX) m_wr = 1;
    m_addr = (m_addr + 1) % (AMAX + 1);
    m_ww++;
  endtask

  task automatic m_tick();
    int sz;
    if (!rst_n) begin m_reset(); return; end
    sz = m_q.size();
    case (m_phase)
      0: if (start) begin
           m_phase = 1; m_addr = int'(base_addr); m_ww = 0; m_ill = 0; m_wr = 0;
         end
      1: begin
           if (sz > 0 && mem_ready) m_pop();
           if (in_valid && sz < DEPTH) begin
             if (int'(opcode) < 21) m_q.push_back(enc(int'(opcode), int'(da), int'(aa), int'(ba), int'(imm)));
             else m_ill = 1;
           end
           if (finish) m_phase = 2;
         end
      2: begin
           if (sz > 0 && mem_ready) m_pop();
           if (m_q.size() == 0) m_phase = 3;
         end
      default: m_phase = 0;
    endcase
  endtask

  task automatic step();
    bit e_we;
    @(negedge clk);
    e_we = (m_phase == 1 || m_phase == 2) && m_q.size() > 0;
    chk("in_ready", in_ready, (m_phase == 1 && m_q.size() < DEPTH));
    chk("mem_we", mem_we, e_we);
    if (e_we) chk("mem_wdata", mem_wdata, m_q[0]);
    chk("mem_addr", mem_addr, m_addr);
    chk("words_written", words_written, m_ww);
    chk("busy", busy, (m_phase == 1 || m_phase == 2));
    chk("done", done, (m_phase == 3));
    chk("illegal", illegal, m_ill);
    chk("wrapped", wrapped, m_wr);
    m_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input int o, input int d, input int a, input int b, input int i);
    opcode = 5'(o); da = 3'(d); aa = 3'(a); ba = 3'(b); imm = 3'(i);
  endtask

  task automatic do_start(input int b);
    start = 1; base_addr = AW'(b);
    step();
    start = 0;
  endtask

  task automatic finish_session();
    in_valid = 0; mem_ready = 1; finish = 1;
    step();
    finish = 0;
    for (int k = 0; k < 20 && !done; k++) step();
    chk("done_seen", done, 1);
    step();
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_outs"}, {in_ready, mem_we, busy, done, illegal, wrapped}, 0);
    chk({nm, "_addr"}, mem_addr, 0);
    chk({nm, "_wdata"}, mem_wdata, 0);
    chk({nm, "_ww"}, words_written, 0);
  endtask

  initial begin
    logic [AW-1:0] addrs[$];
    int writes, last_w, c;
    bit acc;

    tbl[0] = '{0, 1, 2, 3, 0, 17'h00298};
    tbl[1] = '{20, 7, 7, 7, 7, 17'h14FFF};
    tbl[2] = '{5, 0, 0, 0, 5, 17'h05005};
    tbl[3] = '{1, 4, 5, 6, 1, 17'h01971};
    tbl[4] = '{16, 3, 0, 7, 2, 17'h1063A};

    rst_n = 0; start = 0; finish = 0; in_valid = 0; mem_ready = 0;
    base_addr = '0; set_instr(0, 0, 0, 0, 0);
    m_reset();
    #3;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1;
    step();

    // Base 0x10, first word lands the cycle after acceptance.
    do_start(8'h10);
    set_instr(0, 1, 2, 3, 0); in_valid = 1;
    step();
    in_valid = 0;
    chk("first_we", mem_we, 1);
    chk("first_addr", mem_addr, 8'h10);
    chk("first_wdata", mem_wdata, 17'h00298);
    mem_ready = 1;
    step();
    mem_ready = 0;
    chk("first_ww", words_written, 1);

    // Illegal opcode is swallowed, then a legal one goes through.
    set_instr(21, 1, 1, 1, 1); in_valid = 1;
    step();
    in_valid = 0;
    chk("ill_we", mem_we, 0);
    chk("ill_flag", illegal, 1);
    chk("ill_ww", words_written, 1);
    step();
    set_instr(20, 1, 1, 1, 1); in_valid = 1;
    step();
    in_valid = 0;
    chk("op20_we", mem_we, 1);
    chk("op20_wdata", mem_wdata, enc(20, 1, 1, 1, 1));
    mem_ready = 1;
    step();
    chk("op20_ww", words_written, 2);
    finish_session();

    // Encoding table.
    do_start(8'h30);
    for (int i = 0; i < 5; i++) begin
      set_instr(tbl[i].op, tbl[i].da, tbl[i].aa, tbl[i].ba, tbl[i].imm);
      in_valid = 1; mem_ready = 0;
      step();
      in_valid = 0;
      chk($sformatf("tbl%0d_wdata", i), mem_wdata, tbl[i].exp);
      mem_ready = 1;
      step();
    end
    finish_session();

    // Backpressure: buffer fills at DEPTH, then drains on consecutive cycles.
    do_start(8'h40);
    mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      chk("fill_ready", in_ready, 1);
      set_instr(i + 1, i, 7 - i, i, 3); in_valid = 1;
      step();
    end
    chk("full_ready", in_ready, 0);
    set_instr(9, 1, 2, 3, 4);
    step();
    chk("full_hold", in_ready, 0);
    mem_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("burst_we", mem_we, 1);
      chk("burst_addr", mem_addr, 8'h40 + k);
      acc = in_valid && in_ready;
      step();
      if (acc) in_valid = 0;
    end
    chk("fifth_ww", words_written, 4);
    chk("fifth_wdata", mem_wdata, enc(9, 1, 2, 3, 4));
    finish_session();

    // Address wrap.
    do_start(8'hFE);
    mem_ready = 1;
    addrs.delete();
    for (int k = 0; k < 8; k++) begin
      in_valid = (k < 3);
      set_instr(2, k, k, k, k);
      if (mem_we && mem_ready) addrs.push_back(mem_addr);
      step();
    end
    in_valid = 0;
    chk("wrap_count", addrs.size(), 3);
    if (addrs.size() == 3) begin
      chk("wrap_a0", addrs[0], 8'hFE);
      chk("wrap_a1", addrs[1], 8'hFF);
      chk("wrap_a2", addrs[2], 8'h00);
    end
    chk("wrap_flag", wrapped, 1);
    chk("wrap_ww", words_written, 3);
    finish_session();

    // Drain after finish with three queued words.
    do_start(8'h20);
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_instr(i + 3, 1, 2, 3, i); in_valid = 1;
      step();
    end
    in_valid = 0; finish = 1;
    step();
    finish = 0;
    chk("drain_busy", busy, 1);
    chk("drain_ready", in_ready, 0);
    mem_ready = 1; writes = 0; last_w = -10;
    for (c = 0; c < 10 && !done; c++) begin
      if (mem_we) begin writes++; last_w = c; end
      step();
    end
    chk("drain_done", done, 1);
    chk("drain_writes", writes, 3);
    chk("drain_done_lat", c - last_w, 1);
    step();
    chk("drain_pulse", done, 0);
    chk("drain_idle", busy, 0);

    // Reset in the middle of a session with two words buffered.
    do_start(8'h50);
    mem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      set_instr(7, i, i, i, i); in_valid = 1;
      step();
    end
    in_valid = 0;
    chk("pre_rst_we", mem_we, 1);
    #2 rst_n = 0;
    #1;
    chk_all_zero("midrst");
    m_reset();
    step();
    rst_n = 1; in_valid = 1; mem_ready = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_we", mem_we, 0);
    end
    in_valid = 0;

    // Randomized sessions.
    for (int s = 0; s < 6; s++) begin
      do_start(int'($urandom_range(0, AMAX)));
      for (int k = 0; k < 40; k++) begin
        in_valid  = ($urandom_range(0, 9) < 6);
        set_instr(int'($urandom_range(0, 31)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        mem_ready = 1'($urandom_range(0, 1));
        start     = ($urandom_range(0, 19) == 0);
        base_addr = AW'($urandom_range(0, AMAX));
        finish    = ($urandom_range(0, 29) == 0);
        step();
      end
      start = 0; finish = 0; in_valid = 0;
      if (done) step();
      if (busy) finish_session();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
